fetch_queue: RTL and testbench

- Decoupled, parametrised instruction-fetch front end for the pipelined RV32I core.
- Generates sequential PCs and drives the IMEM port (BRAM port A, 1-cycle read latency).
- Buffers {pc, instr} pairs in a DEPTH-entry queue and presents them to decode over a valid/ready handshake.
- Handles control-flow redirects from EX with a full flush and a zero-bubble restart, including killing the in-flight IMEM response.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/sync_fifo.sv | 72 +++++++
 rtl/fetch_queue.sv | 98 +++++++++
 tb/tb_fetch_queue.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants and helpers for the instruction-fetch front end.
package fetch_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_INC  = 4;

    // Instruction shown to decode while the queue is empty (addi x0, x0, 0).
    localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0013;

    // Widest PC the alignment helper handles; callers size in and out with casts.
    localparam int ALIGN_W = 64;

    // Clear the byte offset so the address points at a whole instruction word.
    function automatic logic [ALIGN_W-1:0] align_pc(input logic [ALIGN_W-1:0] pc);
        return pc & ~ALIGN_W'(3);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; the head entry is read combinationally from storage.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           push_data_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           head_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    // Pointer and occupancy next-state; flush wins over any push or pop.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a latch behind.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments keep every register sampling pre-edge values.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port.
    always_ff @(posedge clk) begin
        // NOTE: storage has no reset; occupancy alone decides which entries are meaningful.
        if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/fetch_queue.sv
// Decoupled instruction fetch: sequential PC generation, IMEM request/response,
// {pc, instr} queue towards decode, and full flush on EX redirects.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_en,
    output logic [XLEN-1:0]            imem_addr,
    input  logic [INSTR_W-1:0]         imem_rdata,
    input  logic                       redirect_valid,
    input  logic [XLEN-1:0]            redirect_pc,
    output logic                       deq_valid,
    input  logic                       deq_ready,
    output logic [XLEN-1:0]            deq_pc,
    output logic [INSTR_W-1:0]         deq_instr,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = XLEN + INSTR_W;

    logic [XLEN-1:0]    pc_q, pc_d;
    logic [XLEN-1:0]    infl_pc_q, infl_pc_d;
    logic               infl_q, infl_d;
    logic               issue, push, pop;
    logic               fifo_full, fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic [CNT_W:0]     occupancy;

    // Queued entries plus the outstanding request: each request owns a slot before it returns.
    assign occupancy = {1'b0, count} + {{CNT_W{1'b0}}, infl_q};

    // A redirect always fetches its target; otherwise fetch only while a slot is free.
    assign issue = !rst && (redirect_valid || (!fifo_full && occupancy < (CNT_W+1)'(DEPTH)));
    assign imem_en = issue;

    // Fetch address: reset PC, aligned redirect target, or the next sequential PC.
    always_comb begin
        if (rst)                 imem_addr = RESET_PC;
        else if (redirect_valid) imem_addr = XLEN'(align_pc(ALIGN_W'(redirect_pc)));
        else                     imem_addr = pc_q;
    end

    // Fetch PC and in-flight tracking next-state.
    always_comb begin
        pc_d      = pc_q;
        infl_d    = 1'b0;
        infl_pc_d = infl_pc_q;
        if (issue) begin
            pc_d      = imem_addr + XLEN'(PC_INC);
            infl_d    = 1'b1;
            infl_pc_d = imem_addr;
        end
    end

    // Fetch PC and in-flight registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q      <= RESET_PC;
            infl_q    <= 1'b0;
            infl_pc_q <= '0;
        end else begin
            pc_q      <= pc_d;
            infl_q    <= infl_d;
            infl_pc_q <= infl_pc_d;
        end
    end

    // A response arriving alongside a redirect belongs to the wrong path and is dropped.
    assign push      = infl_q && !redirect_valid && !rst;
    assign deq_valid = !fifo_empty && !redirect_valid && !rst;
    assign pop       = deq_valid && deq_ready;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect_valid),
        .push_i      (push),
        .push_data_i ({infl_pc_q, imem_rdata}),
        .pop_i       (pop),
        .head_o      (head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (count)
    );

    assign deq_pc    = head[ENTRY_W-1:INSTR_W];
    assign deq_instr = fifo_empty ? NOP_INSTR : head[INSTR_W-1:0];

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed scenarios on a DEPTH=4 instance plus random
// traffic on DEPTH=4/2/8 instances, each compared every cycle to a queue model.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        rv;
    logic [31:0] rpc;
    logic        rdy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // IMEM contents: word n holds 0x1000 + n.
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return 32'h1000 + (a >> 2);
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int          D   = (g == 0) ? 4 : (g == 1) ? 2 : 8;
        localparam logic [31:0] RPC = (g == 2) ? 32'h80 : 32'h0;
        localparam int          CW  = $clog2(D + 1);

        logic          en, vld;
        logic [31:0]   addr, rdata, dpc, dinstr;
        logic [CW-1:0] cnt;

        fetch_queue #(.XLEN(32), .DEPTH(D), .RESET_PC(RPC)) u_dut (
            .clk            (clk),
            .rst            (rst),
            .imem_en        (en),
            .imem_addr      (addr),
            .imem_rdata     (rdata),
            .redirect_valid (rv),
            .redirect_pc    (rpc),
            .deq_valid      (vld),
            .deq_ready      (rdy),
            .deq_pc         (dpc),
            .deq_instr      (dinstr),
            .count          (cnt)
        );

        // One-cycle-latency instruction memory.
        always @(posedge clk) if (en) rdata <= word_at(addr);

        // Reference model: queued PCs in fetch order, one pending request, next PC.
        logic [31:0] m_q[$];
        logic [31:0] m_next, m_pend_pc;
        bit          m_pend, m_live;

        function automatic bit m_en();
            return !rst && (rv || (m_q.size() + int'(m_pend) < D));
        endfunction
        function automatic logic [31:0] m_addr();
            return rst ? RPC : rv ? (rpc & 32'hFFFF_FFFC) : m_next;
        endfunction
        function automatic bit m_vld();
            return !rst && !rv && (m_q.size() != 0);
        endfunction

        // Compare DUT outputs to the model mid-cycle.
        always @(negedge clk) begin
            if (m_live) begin
                check($sformatf("d%0d_imem_en", D),   64'(en),   64'(m_en()));
                check($sformatf("d%0d_imem_addr", D), 64'(addr), 64'(m_addr()));
                check($sformatf("d%0d_deq_valid", D), 64'(vld),  64'(m_vld()));
                check($sformatf("d%0d_count", D),     64'(cnt),  64'(m_q.size()));
                check($sformatf("d%0d_no_overflow", D), 64'(int'(cnt) <= D), 64'(1));
                check($sformatf("d%0d_no_pop_empty", D), 64'(!(vld && cnt == '0)), 64'(1));
                if (m_vld()) begin
                    check($sformatf("d%0d_deq_pc", D),    64'(dpc),    64'(m_q[0]));
                    check($sformatf("d%0d_deq_instr", D), 64'(dinstr), 64'(word_at(m_q[0])));
                end else if (m_q.size() == 0) begin
                    check($sformatf("d%0d_empty_instr", D), 64'(dinstr), 64'(NOP));
                end
            end
        end

        // Advance the model at the clock edge.
        always @(posedge clk) begin : upd
            bit          issue, pop;
            logic [31:0] a;
            issue = m_en();
            a     = m_addr();
            pop   = m_vld() && rdy;
            if (rst) begin
                m_q.delete();
                m_next = RPC;
                m_pend = 1'b0;
                m_live = 1'b1;
            end else begin
                if (pop) void'(m_q.pop_front());
                if (rv) m_q.delete();
                else if (m_pend) m_q.push_back(m_pend_pc);
                m_pend = issue;
                if (issue) begin
                    m_pend_pc = a;
                    m_next    = a + 32'd4;
                end
            end
        end
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; rv = 1'b0; rpc = '0; rdy = 1'b1;

        // Reset state.
        next_cycle();
        next_cycle();
        @(negedge clk);
        check("rst_imem_en",   64'(g_dut[0].en),   64'(0));
        check("rst_imem_addr", 64'(g_dut[0].addr), 64'(0));
        check("rst_deq_valid", 64'(g_dut[0].vld),  64'(0));
        check("rst_count",     64'(g_dut[0].cnt),  64'(0));
        next_cycle();
        rst = 1'b0;

        // Streaming start: fetch every cycle, decode sees data two cycles after first issue.
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("stream_addr",  64'(g_dut[0].addr), 64'(4 * k));
            check("stream_valid", 64'(g_dut[0].vld),  64'(k >= 2));
            if (k >= 2) begin
                check("stream_pc",    64'(g_dut[0].dpc),    64'(4 * (k - 2)));
                check("stream_instr", 64'(g_dut[0].dinstr), 64'(32'h1000 + k - 2));
            end
            next_cycle();
        end

        // Back-pressure: queue fills to 4 and fetching stops; release drains in order.
        rst = 1'b1; rdy = 1'b0;
        next_cycle();
        rst = 1'b0;
        repeat (6) next_cycle();
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            check("stall_imem_en", 64'(g_dut[0].en),  64'(0));
            check("stall_count",   64'(g_dut[0].cnt), 64'(4));
            next_cycle();
        end
        rdy = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            check("drain_valid", 64'(g_dut[0].vld), 64'(1));
            check("drain_pc",    64'(g_dut[0].dpc), 64'(4 * j));
            next_cycle();
        end

        // Flush with entries queued and one response in flight.
        rv = 1'b1; rpc = 32'h20; rdy = 1'b0;
        next_cycle();
        rv = 1'b0;
        repeat (3) next_cycle();
        rv = 1'b1; rpc = 32'h100; rdy = 1'b1;
        @(negedge clk);
        check("flush_pre_count", 64'(g_dut[0].cnt),  64'(3));
        check("flush_addr",      64'(g_dut[0].addr), 64'(32'h100));
        check("flush_imem_en",   64'(g_dut[0].en),   64'(1));
        check("flush_valid",     64'(g_dut[0].vld),  64'(0));
        next_cycle();
        rv = 1'b0;
        @(negedge clk);
        check("flush_count", 64'(g_dut[0].cnt), 64'(0));
        check("flush_gap",   64'(g_dut[0].vld), 64'(0));
        next_cycle();
        @(negedge clk);
        check("flush_pc0",    64'(g_dut[0].dpc),    64'(32'h100));
        check("flush_instr0", 64'(g_dut[0].dinstr), 64'(32'h1040));
        next_cycle();
        @(negedge clk);
        check("flush_pc1",    64'(g_dut[0].dpc),    64'(32'h104));
        check("flush_instr1", 64'(g_dut[0].dinstr), 64'(32'h1041));
        next_cycle();

        // Back-to-back redirects: only the second stream survives.
        rv = 1'b1; rpc = 32'h200;
        @(negedge clk);
        check("rr_addr0", 64'(g_dut[0].addr), 64'(32'h200));
        next_cycle();
        rpc = 32'h300;
        @(negedge clk);
        check("rr_addr1", 64'(g_dut[0].addr), 64'(32'h300));
        next_cycle();
        rv = 1'b0;
        @(negedge clk);
        check("rr_count", 64'(g_dut[0].cnt),  64'(0));
        check("rr_addr2", 64'(g_dut[0].addr), 64'(32'h304));
        next_cycle();
        @(negedge clk);
        check("rr_pc0", 64'(g_dut[0].dpc), 64'(32'h300));
        next_cycle();
        @(negedge clk);
        check("rr_pc1", 64'(g_dut[0].dpc), 64'(32'h304));
        next_cycle();

        // Misaligned target, PC wrap, and reset beating redirect.
        rv = 1'b1; rpc = 32'h102;
        @(negedge clk);
        check("misalign_addr", 64'(g_dut[0].addr), 64'(32'h100));
        next_cycle();
        rpc = 32'hFFFF_FFFC;
        @(negedge clk);
        check("wrap_addr0", 64'(g_dut[0].addr), 64'(32'hFFFF_FFFC));
        next_cycle();
        rv = 1'b0;
        @(negedge clk);
        check("wrap_addr1", 64'(g_dut[0].addr), 64'(0));
        next_cycle();
        @(negedge clk);
        check("wrap_pc0",    64'(g_dut[0].dpc),    64'(32'hFFFF_FFFC));
        check("wrap_instr0", 64'(g_dut[0].dinstr), 64'(32'h4000_0FFF));
        next_cycle();
        @(negedge clk);
        check("wrap_pc1", 64'(g_dut[0].dpc), 64'(0));
        next_cycle();
        rst = 1'b1; rv = 1'b1; rpc = 32'h500;
        @(negedge clk);
        check("rstrd_imem_en", 64'(g_dut[0].en),   64'(0));
        check("rstrd_addr",    64'(g_dut[0].addr), 64'(0));
        check("rstrd_valid",   64'(g_dut[0].vld),  64'(0));
        next_cycle();
        rst = 1'b0; rv = 1'b0;
        @(negedge clk);
        check("rstrd_count", 64'(g_dut[0].cnt),  64'(0));
        check("rstrd_pc",    64'(g_dut[0].addr), 64'(0));

        // Random back-pressure, sparse redirects and rare resets.
        for (int i = 0; i < 3000; i++) begin
            next_cycle();
            if ((i / 250) % 2 == 1) rdy = ($urandom_range(0, 3) == 0);
            else                    rdy = ($urandom_range(0, 3) != 0);
            rv  = ($urandom_range(0, 19) == 0);
            rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF))
                                              : ($urandom & 32'h0000_FFFF);
            rst = ($urandom_range(0, 399) == 0);
        end
        next_cycle();
        rst = 1'b1; rv = 1'b0;
        next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
